// File: rtl/div_share_sched.sv
// Round-robin front end that time-shares one iterative unsigned divider among
// N_REQ requesters, with a watchdog that aborts a divide that never completes.
module div_share_sched #(
  parameter int WIDTH   = 4,
  parameter int N_REQ   = 3,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_q,
  output logic [WIDTH-1:0]       rsp_r,
  output logic                   rsp_dbz,
  output logic                   rsp_err,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_x,
  output logic [WIDTH-1:0]       div_y,
  input  logic                   div_busy,
  input  logic                   div_valid,
  input  logic                   div_dbz,
  input  logic [WIDTH-1:0]       div_q,
  input  logic [WIDTH-1:0]       div_r
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SW   = ID_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [WD_W-1:0]  wd_cnt;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_found;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic [SW-1:0]    scan_sum;
  logic [ID_W-1:0]  scan_id;

  logic             wait_dbz, wait_done, wait_to, wait_exit;

  logic [WIDTH-1:0] x_arr [N_REQ];
  logic [WIDTH-1:0] y_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[i*WIDTH +: WIDTH];
    assign y_arr[i] = req_y[i*WIDTH +: WIDTH];
  end

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  // Scan requesters starting at rr_ptr, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    scan_sum  = '0;
    scan_id   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + SW'(k);
      if (scan_sum >= SW'(N_REQ)) scan_sum = scan_sum - SW'(N_REQ);
      scan_id = scan_sum[ID_W-1:0];
      if (!gnt_found && req_valid[scan_id]) begin
        gnt_found    = 1'b1;
        gnt[scan_id] = 1'b1;
        gnt_id       = scan_id;
        sel_x        = x_arr[scan_id];
        sel_y        = y_arr[scan_id];
      end
    end
  end

  // Reset also forces the grant low, since the grant is combinational in IDLE.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;

  assign wait_dbz  = div_dbz && !div_busy;
  assign wait_done = div_valid;
  assign wait_to   = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign wait_exit = wait_dbz || wait_done || wait_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_found) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wait_exit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      wd_cnt    <= '0;
      div_start <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dbz   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      div_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            cur_id    <= gnt_id;
            div_x     <= sel_x;
            div_y     <= sel_y;
            rr_ptr    <= next_ptr(gnt_id);
            div_start <= 1'b1;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          // Divider outputs are trusted only here; dbz outranks a stale valid.
          if (wait_dbz) begin
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b1;
            rsp_err <= 1'b0;
          end else if (wait_done) begin
            rsp_q   <= div_q;
            rsp_r   <= div_r;
            rsp_dbz <= 1'b0;
            rsp_err <= 1'b0;
          end else if (wait_to) begin
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b0;
            rsp_err <= 1'b1;
          end
          if (wait_exit) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Round-robin scheduler that shares one iterative WIDTH-bit unsigned divider among N_REQ requesters in the fetal-ECG datapath.
- Accepts one request (dividend, divisor) at a time through valid/ready and drives the divider's start/x/y.
- Watches the divider's busy/valid/dbz and returns quotient, remainder, dbz and requester id on a shared response bus.
- Includes a watchdog that aborts a hung divide.

Parameters:
- WIDTH, 4, operand/result width; must match the divider.
- N_REQ, 3, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of rsp_id.
- TIMEOUT, WIDTH+4, maximum WAIT cycles before abort.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant/accept, combinational in IDLE
- req_x  in  N_REQ*WIDTH  packed dividends, slice i = requester i
- req_y  in  N_REQ*WIDTH  packed divisors
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  ID_W  requester index of the response
- rsp_q  out  WIDTH  quotient
- rsp_r  out  WIDTH  remainder
- rsp_dbz  out  1  divide-by-zero flag
- rsp_err  out  1  watchdog abort flag (rsp_q and rsp_r = 0)
- div_start  out  1  divider start, one-cycle pulse
- div_x  out  WIDTH  registered dividend to divider
- div_y  out  WIDTH  registered divisor to divider
- div_busy  in  1  divider busy
- div_valid  in  1  divider result valid; level, stays set until the next start
- div_dbz  in  1  divider divide-by-zero flag
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE, rr_ptr=0, req_ready=0.
  - div_start=0, div_x=0, div_y=0.
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dbz=0, rsp_err=0.
  - wd_cnt=0.
- Divider outputs are undefined after reset and are stale between operations. They are sampled only in WAIT.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ... (mod N_REQ).
  - req_ready is asserted for that one requester only, combinationally, in the same cycle.
  - On handshake: latch the id, load div_x/div_y from that requester's slice, set rr_ptr = id+1 (wrap N_REQ-1 -> 0), go to ISSUE.
  - req_ready=0 in every other state. No queuing; unserved requesters hold valid.
- ISSUE: div_start=1 for exactly this one cycle. wd_cnt=0. Go to WAIT.
- WAIT (checks in priority order):
  - div_dbz=1 and div_busy=0 -> capture dbz=1, q=0, r=0; go to RESP.
  - Else div_valid=1 -> capture div_q and div_r, dbz=0; go to RESP.
  - Else wd_cnt increments; wd_cnt == TIMEOUT-1 -> err=1, q=r=0; go to RESP.
- RESP: rsp_valid=1 for one cycle with the captured fields and rsp_id. Go to IDLE.
  - A new grant can occur in the IDLE cycle that follows.
- Response outputs hold their values between pulses. Only rsp_valid is a pulse.
- Latency, from the accept cycle A:
  - div_start at A+1.
  - Normal result: rsp_valid at A+3+WIDTH.
  - Divide by zero: rsp_valid at A+3.
  - Watchdog abort: rsp_valid at A+2+TIMEOUT.
- Throughput: one divide every WIDTH+4 cycles.
- Boundary conditions:
  - All req_valid low: IDLE holds and nothing is issued.
  - A requester that drops req_valid before being granted is never served. Requests are not latched.
  - Simultaneous requests: round-robin gives each active requester exactly one grant per N_REQ grants.
  - rr_ptr wraps from N_REQ-1 to 0.
  - Reset mid-operation returns to IDLE immediately and emits no response. The divider is restarted cleanly on the next ISSUE.

Test Plan:
- WIDTH=4, N_REQ=3, only req1 with x=13, y=3 -> req_ready=3'b010 same cycle; div_start one cycle later; rsp_valid 7 cycles after accept; rsp_id=1, q=4, r=1, dbz=0.
- req0 with x=9, y=0 -> rsp_valid 3 cycles after accept; rsp_dbz=1, q=0, r=0, err=0.
- All three requesting continuously (x=15, y=2/5/7) -> grant order 0,1,2,0,1,2; results q=7/r=1, q=3/r=0, q=2/r=1; grants 8 cycles apart.
- After a req2 grant, req0 and req2 both valid -> rr_ptr wraps to 0 and req0 is granted first.
- Divider model holds div_busy=1 and never asserts valid -> rsp_err=1 at A+10 (TIMEOUT=8); the next request is served normally.
- rst_n pulsed low during WAIT -> all outputs zero asynchronously, no rsp_valid; a following request to 14/4 returns q=3, r=2.
